id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
//  ID-stage producer of the EX-stage ALU control interface. Decodes RV32I instruction words into
//  the 4-bit ALUCode, operand selects, immediate and control flags, then registers them as the
//  ID/EX pipeline register. Stall holds the register; flush inserts a bubble. Sits between the
//  fetch/decode path and the EX-stage ALU and operand muxes.
// PARAMETERS
//  PC_W          32  width of PC carried to EX
//  ILLEGAL_KILL  1   1: illegal instruction forces RegWrite/MemRead/MemWrite/Branch/Jump to 0
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     asynchronous, active-high
//  stall         in   1     hold ID/EX contents (hazard unit)
//  flush         in   1     load bubble into ID/EX (branch/jump redirect)
//  id_valid      in   1     id_instr/id_pc hold a real instruction
//  id_instr      in   32    instruction word
//  id_pc         in   PC_W  PC of id_instr
//  ex_valid      out  1     ID/EX holds a real instruction
//  ex_ALUCode    out  4     add 0000,sub 0001,lui 0010,and 0011,xor 0100,or 0101,sll 0110,
//                           srl 0111,sra 1000,slt 1001,sltu 1010
//  ex_ALUSrcA    out  1     0 rs1 data, 1 PC
//  ex_ALUSrcB    out  2     00 rs2 data, 01 ex_imm, 10 constant 4
//  ex_imm        out  32    sign-extended immediate (shifts: {27'b0,shamt})
//  ex_pc         out  PC_W  registered id_pc
//  ex_rs1/ex_rs2 out  5     source register addresses (forwarding)
//  ex_rd         out  5     destination register
//  ex_funct3     out  3     for branch compare / load-store sizing
//  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump  out 1 each
//  ex_illegal    out  1     unsupported opcode/funct combination
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-stall): every output 0; ex_ALUCode=0000 (add).
//  - Latency 1 cycle: decode comb from id_instr, captured on rising clk.
//  - Priority per edge: reset > flush > stall > load. Flush while stalled => bubble.
//  - Bubble = all outputs 0 (ex_valid=0, all control flags 0, ALUCode add).
//  - Stall: all outputs hold; id_* ignored. id_valid=0 without stall/flush => bubble.
//  - Decode (opcode -> ALUCode, SrcA, SrcB):
//     R 0110011: f3/f7 -> add/sub(f7[5]=1,f3=000)/sll/slt/sltu/xor/srl/sra(f7[5])/or/and; A0 B00
//     I 0010011: same map, f7 used only for f3=101; addi never sub; A0 B01
//     LUI 0110111 -> lui, B01, imm={instr[31:12],12'b0}; AUIPC 0010111 -> add, A1 B01
//     LOAD 0000011 -> add A0 B01, MemRead, MemtoReg; STORE 0100011 -> add A0 B01 MemWrite, S-imm
//     BRANCH 1100011 -> sub A0 B00, Branch, B-imm; JAL 1101111 -> add A1 B10, Jump, J-imm
//     JALR 1100111 (f3=000) -> add A1 B10, Jump, I-imm (target adder outside this block)
//  - RegWrite=1 for R, I, LUI, AUIPC, LOAD, JAL, JALR; forced 0 when rd=x0.
//  - Illegal: other opcodes; R f7 not 0000000/0100000 or 0100000 with f3 not 000/101;
//    slli/srli/srai with f7 not 0000000/0100000 (0100000 only on f3=101); JALR f3!=000.
//    Sets ex_illegal=1, ALUCode add, ex_valid=1; ILLEGAL_KILL=1 clears side-effect flags.
//  - Immediates: I,S,B,J sign-extended from instr[31]; B/J bit0=0.
// STRUCTURE
//  - Shared include alu_defs.vh: ALUCode localparams (11 codes), opcode constants, SrcB codes;
//    the same file is used by the EX-stage ALU.
//  - One sub-module alu_ctrl_dec (combinational: instr -> ALUCode, selects, flags, imm, illegal);
//    this block adds the stall/flush pipeline register around it.
// TESTING
//  1 id_instr=0x002081B3 (add x3,x1,x2) -> next edge: ALUCode 0000, SrcA 0, SrcB 00, rd 3,
//    RegWrite 1, ex_valid 1
//  2 0x407302B3 (sub x5,x6,x7) -> ALUCode 0001; 0x40315093 (srai x1,x2,3) -> ALUCode 1000,
//    SrcB 01, ex_imm 0x00000003
//  3 0x123450B7 (lui x1,0x12345) -> ALUCode 0010, SrcB 01, ex_imm 0x12345000, RegWrite 1
//  4 load add, assert stall 3 cycles while id_instr changes -> outputs unchanged; stall+flush
//    same edge -> ex_valid 0, all flags 0
//  5 0xFFFFFFFF -> ex_illegal 1, RegWrite 0, MemWrite 0; add with rd=x0 -> RegWrite 0
//  6 assert reset between edges mid-stream -> outputs 0 immediately, no clock needed;
//    first edge after release loads fresh decode

Source files
------------

// File: rtl/id_ex_alu_issue_pkg.sv
// id_ex_alu_issue_pkg: ALU codes, opcodes, operand-select codes and the decoded control bundle
//   shared by the ID-stage decoder, the ID/EX register and the EX-stage ALU.
package id_ex_alu_issue_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // All-zero value of this bundle is the pipeline bubble (ALUCode add).
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_code;
    logic        src_a;
    logic [1:0]  src_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ctrl_t;

  // funct3 -> ALU operation; alt selects sub / sra on the shared encodings.
  function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic alt);
    return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/id_ex_alu_issue_alu_ctrl_dec.sv
// id_ex_alu_issue_alu_ctrl_dec: combinational RV32I decode of one instruction word.
//   i_instr  in  32   instruction word
//   o_ctrl   out      ALUCode, operand selects, immediate, register fields, flags, illegal
module id_ex_alu_issue_alu_ctrl_dec
  import id_ex_alu_issue_pkg::*;
#(
  parameter bit ILLEGAL_KILL = 1'b1
) (
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl
);
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_alt;
  logic        w_f7_ok;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  assign w_op    = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_alt   = w_f7 == F7_ALT;
  assign w_f7_ok = w_f7 == F7_BASE || w_alt;
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  always_comb begin
    o_ctrl        = '0;
    o_ctrl.valid  = 1'b1;
    o_ctrl.rs1    = i_instr[19:15];
    o_ctrl.rs2    = i_instr[24:20];
    o_ctrl.rd     = i_instr[11:7];
    o_ctrl.funct3 = w_f3;
    case (w_op)
      OP_R: begin
        o_ctrl.alu_code  = arith_code(w_f3, w_alt);
        o_ctrl.src_b     = SRCB_RS2;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.illegal   = !w_f7_ok || (w_alt && w_f3 != 3'b000 && w_f3 != 3'b101);
      end
      OP_I: begin
        // Only the shift-right form consults funct7; addi can never become sub.
        o_ctrl.alu_code  = arith_code(w_f3, w_alt && w_f3 == 3'b101);
        o_ctrl.src_b     = SRCB_IMM;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.imm       = (w_f3 == 3'b001 || w_f3 == 3'b101) ? {27'b0, i_instr[24:20]} : w_imm_i;
        o_ctrl.illegal   = w_f3 == 3'b001 ? w_f7 != F7_BASE : w_f3 == 3'b101 ? !w_f7_ok : 1'b0;
      end
      OP_LUI: begin
        o_ctrl.alu_code  = ALU_LUI;
        o_ctrl.src_b     = SRCB_IMM;
        o_ctrl.imm       = w_imm_u;
        o_ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        o_ctrl.src_a     = 1'b1;
        o_ctrl.src_b     = SRCB_IMM;
        o_ctrl.imm       = w_imm_u;
        o_ctrl.reg_write = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.src_b      = SRCB_IMM;
        o_ctrl.imm        = w_imm_i;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.src_b     = SRCB_IMM;
        o_ctrl.imm       = w_imm_s;
        o_ctrl.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.alu_code = ALU_SUB;
        o_ctrl.src_b    = SRCB_RS2;
        o_ctrl.imm      = w_imm_b;
        o_ctrl.branch   = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.src_a     = 1'b1;
        o_ctrl.src_b     = SRCB_FOUR;
        o_ctrl.imm       = w_imm_j;
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        // ALU produces the link value PC+4; the jump target adder lives elsewhere.
        o_ctrl.src_a     = 1'b1;
        o_ctrl.src_b     = SRCB_FOUR;
        o_ctrl.imm       = w_imm_i;
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.illegal   = w_f3 != 3'b000;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
    if (o_ctrl.rd == 5'd0) o_ctrl.reg_write = 1'b0;
    if (o_ctrl.illegal) begin
      o_ctrl.alu_code = ALU_ADD;
      if (ILLEGAL_KILL) begin
        o_ctrl.reg_write = 1'b0;
        o_ctrl.mem_read  = 1'b0;
        o_ctrl.mem_write = 1'b0;
        o_ctrl.branch    = 1'b0;
        o_ctrl.jump      = 1'b0;
      end
    end
  end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID-stage decode of RV32I words registered into the ID/EX pipeline register.
//   clk, reset (async, active-high), stall (hold), flush (bubble), id_valid/id_instr/id_pc in;
//   ex_* out: valid, ALUCode, ALUSrcA/B, imm, pc, rs1/rs2/rd, funct3, control flags, illegal.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter bit ILLEGAL_KILL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc,
  output logic            ex_valid,
  output logic [3:0]      ex_ALUCode,
  output logic            ex_ALUSrcA,
  output logic [1:0]      ex_ALUSrcB,
  output logic [31:0]     ex_imm,
  output logic [PC_W-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_MemtoReg,
  output logic            ex_Branch,
  output logic            ex_Jump,
  output logic            ex_illegal
);
  ctrl_t           w_dec;
  ctrl_t           r_ex;
  logic [PC_W-1:0] r_pc;
  id_ex_alu_issue_alu_ctrl_dec #(.ILLEGAL_KILL(ILLEGAL_KILL)) u_dec (
    .i_instr(id_instr),
    .o_ctrl (w_dec)
  );
  // Flush beats stall so a redirect always squashes a held instruction.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ex <= '0;
      r_pc <= '0;
    end else if (flush) begin
      r_ex <= '0;
      r_pc <= '0;
    end else if (!stall) begin
      r_ex <= id_valid ? w_dec : '0;
      r_pc <= id_valid ? id_pc : '0;
    end
  assign ex_valid    = r_ex.valid;
  assign ex_ALUCode  = r_ex.alu_code;
  assign ex_ALUSrcA  = r_ex.src_a;
  assign ex_ALUSrcB  = r_ex.src_b;
  assign ex_imm      = r_ex.imm;
  assign ex_pc       = r_pc;
  assign ex_rs1      = r_ex.rs1;
  assign ex_rs2      = r_ex.rs2;
  assign ex_rd       = r_ex.rd;
  assign ex_funct3   = r_ex.funct3;
  assign ex_RegWrite = r_ex.reg_write;
  assign ex_MemRead  = r_ex.mem_read;
  assign ex_MemWrite = r_ex.mem_write;
  assign ex_MemtoReg = r_ex.mem_to_reg;
  assign ex_Branch   = r_ex.branch;
  assign ex_Jump     = r_ex.jump;
  assign ex_illegal  = r_ex.illegal;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: directed vectors with hand-computed ID/EX contents, checked by a scoreboard monitor.
module tb_id_ex_alu_issue;
  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic        a;
    logic [1:0]  b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        j;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic        ex_valid, ex_ALUSrcA, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic        ex_Branch, ex_Jump, ex_illegal;
  logic [3:0]  ex_ALUCode;
  logic [1:0]  ex_ALUSrcB;
  logic [31:0] ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  last;
  logic  mon_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.PC_W(32), .ILLEGAL_KILL(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_ALUCode(ex_ALUCode), .ex_ALUSrcA(ex_ALUSrcA),
    .ex_ALUSrcB(ex_ALUSrcB), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
    .ex_illegal(ex_illegal)
  );

  // fl = {RegWrite, MemRead, MemWrite, MemtoReg, Branch, Jump}
  function automatic exp_t mk(input logic [3:0] alu, input logic a, input logic [1:0] b,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [5:0] fl, input logic ill);
    return {1'b1, alu, a, b, imm, pc, rs1, rs2, rd, f3, fl, ill};
  endfunction

  task automatic drive(input string n, input logic [31:0] instr, input logic [31:0] pc,
                       input logic v, input logic s, input logic f, input exp_t e);
    @(negedge clk);
    reset    = 1'b0;
    id_instr = instr;
    id_pc    = pc;
    id_valid = v;
    stall    = s;
    flush    = f;
    exp_q.push_back(e);
    name_q.push_back(n);
    last = e;
  endtask

  initial begin
    exp_t a;
    exp_t e;
    string n;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL underflow: DUT sampled with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          a = {ex_valid, ex_ALUCode, ex_ALUSrcA, ex_ALUSrcB, ex_imm, ex_pc, ex_rs1, ex_rs2,
               ex_rd, ex_funct3, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
               ex_Branch, ex_Jump, ex_illegal};
          if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ld;
    repeat (2) @(negedge clk);
    exp_q.push_back('0);
    name_q.push_back("reset_state");
    mon_en = 1'b1;
    drive("add", 32'h002081B3, 32'h100, 1, 0, 0,
          mk(4'b0000, 0, 2'b00, 32'h0, 32'h100, 1, 2, 3, 0, 6'b100000, 0));
    drive("sub", 32'h407302B3, 32'h104, 1, 0, 0,
          mk(4'b0001, 0, 2'b00, 32'h0, 32'h104, 6, 7, 5, 0, 6'b100000, 0));
    drive("srai", 32'h40315093, 32'h108, 1, 0, 0,
          mk(4'b1000, 0, 2'b01, 32'h3, 32'h108, 2, 3, 1, 5, 6'b100000, 0));
    drive("lui", 32'h123450B7, 32'h10C, 1, 0, 0,
          mk(4'b0010, 0, 2'b01, 32'h12345000, 32'h10C, 8, 3, 1, 5, 6'b100000, 0));
    ld = mk(4'b0000, 0, 2'b01, 32'h8, 32'h110, 2, 8, 4, 2, 6'b110100, 0);
    drive("load", 32'h00812203, 32'h110, 1, 0, 0, ld);
    drive("stall1", 32'h407302B3, 32'h114, 1, 1, 0, ld);
    drive("stall2", 32'hFFFFFFFF, 32'h118, 1, 1, 0, ld);
    drive("stall3", 32'h123450B7, 32'h11C, 0, 1, 0, ld);
    drive("stall_flush", 32'h002081B3, 32'h120, 1, 1, 1, '0);
    drive("illegal_op", 32'hFFFFFFFF, 32'h124, 1, 0, 0,
          mk(4'b0000, 0, 2'b00, 32'h0, 32'h124, 31, 31, 31, 7, 6'b000000, 1));
    drive("add_x0", 32'h00208033, 32'h128, 1, 0, 0,
          mk(4'b0000, 0, 2'b00, 32'h0, 32'h128, 1, 2, 0, 0, 6'b000000, 0));
    drive("store", 32'hFE50AE23, 32'h12C, 1, 0, 0,
          mk(4'b0000, 0, 2'b01, 32'hFFFFFFFC, 32'h12C, 1, 5, 28, 2, 6'b001000, 0));
    drive("branch", 32'hFE208CE3, 32'h130, 1, 0, 0,
          mk(4'b0001, 0, 2'b00, 32'hFFFFFFF8, 32'h130, 1, 2, 25, 0, 6'b000010, 0));
    drive("jal", 32'h001000EF, 32'h134, 1, 0, 0,
          mk(4'b0000, 1, 2'b10, 32'h800, 32'h134, 0, 1, 1, 0, 6'b100001, 0));
    drive("jalr", 32'h004280E7, 32'h138, 1, 0, 0,
          mk(4'b0000, 1, 2'b10, 32'h4, 32'h138, 5, 4, 1, 0, 6'b100001, 0));
    drive("jalr_f3", 32'h004290E7, 32'h13C, 1, 0, 0,
          mk(4'b0000, 1, 2'b10, 32'h4, 32'h13C, 5, 4, 1, 1, 6'b000000, 1));
    drive("auipc", 32'h00001117, 32'h140, 1, 0, 0,
          mk(4'b0000, 1, 2'b01, 32'h1000, 32'h140, 0, 0, 2, 1, 6'b100000, 0));
    drive("slli_f7", 32'h40209093, 32'h144, 1, 0, 0,
          mk(4'b0000, 0, 2'b01, 32'h2, 32'h144, 1, 2, 1, 1, 6'b000000, 1));
    drive("r_f7_and", 32'h4020F1B3, 32'h148, 1, 0, 0,
          mk(4'b0000, 0, 2'b00, 32'h0, 32'h148, 1, 2, 3, 7, 6'b000000, 1));
    drive("not_valid", 32'h002081B3, 32'h14C, 0, 0, 0, '0);
    drive("sltu", 32'h0020B1B3, 32'h150, 1, 0, 0,
          mk(4'b1010, 0, 2'b00, 32'h0, 32'h150, 1, 2, 3, 3, 6'b100000, 0));
    drive("xori", 32'hFFF0C193, 32'h154, 1, 0, 0,
          mk(4'b0100, 0, 2'b01, 32'hFFFFFFFF, 32'h154, 1, 31, 3, 4, 6'b100000, 0));
    drive("flush", 32'h002081B3, 32'h158, 1, 0, 1, '0);
    drive("pre_rst", 32'h407302B3, 32'h15C, 1, 0, 0,
          mk(4'b0001, 0, 2'b00, 32'h0, 32'h15C, 6, 7, 5, 0, 6'b100000, 0));
    drive("pre_rst_stall", 32'h002081B3, 32'h160, 1, 1, 0, last);
    @(posedge clk);
    #2;
    exp_q.push_back('0);
    name_q.push_back("async_reset");
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive("after_rst", 32'h00812203, 32'h164, 1, 0, 0,
          mk(4'b0000, 0, 2'b01, 32'h8, 32'h164, 2, 8, 4, 2, 6'b110100, 0));
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
